// File: rtl/swerv_types.sv
// rtl/swerv_types.sv - shared decode/exu types for the divide issue path
package swerv_types;

  localparam logic [5:0] DIV_WDOG_MAX = 6'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } dec_div_state_t;

  typedef struct packed {
    logic valid;
    logic unsign;
    logic rem;
  } div_pkt_t;

endpackage

// File: rtl/dec_div_wdog.sv
// rtl/dec_div_wdog.sv - divide watchdog: counts enabled cycles, flags the limit
module dec_div_wdog
  import swerv_types::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [5:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 6'd0;
    end else if (clr) begin
      count <= 6'd0;
    end else if (en) begin
      count <= count + 6'd1;
    end
  end

  assign expire = en & (count == DIV_WDOG_MAX);

endmodule

// File: rtl/dec_div_issue.sv
// rtl/dec_div_issue.sv - decode-side divide issue, completion tracking and writeback
module dec_div_issue
  import swerv_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_div_valid_d,
  input  logic        dec_div_unsign_d,
  input  logic        dec_div_rem_d,
  input  logic [4:0]  dec_div_rd_d,
  input  logic [31:0] dec_div_rs1_d,
  input  logic [31:0] dec_div_rs2_d,
  output logic        dec_div_ready_d,
  input  logic        flush_lower_wb,
  output logic        div_p_valid,
  output logic        div_p_unsign,
  output logic        div_p_rem,
  output logic [31:0] gpr_div_rs1_d,
  output logic [31:0] gpr_div_rs2_d,
  input  logic        exu_div_stall,
  input  logic        exu_div_finish,
  input  logic [31:0] exu_div_result,
  output logic        div_wen_wb,
  output logic [4:0]  div_waddr_wb,
  output logic [31:0] div_wdata_wb,
  output logic        div_busy,
  output logic        div_timeout_err
);

  dec_div_state_t state, next_state;
  logic [4:0]  rd_q;
  logic        unsign_q, rem_q;
  logic [31:0] rs1_q, rs2_q, result_q;
  logic        accept, capture, wdog_expire, timeout;
  div_pkt_t    pkt;

  // The exu stall only tells us the divider is still working; completion is
  // signalled by finish alone, so it drives no state here.
  logic stall_unused;
  assign stall_unused = exu_div_stall;

  assign dec_div_ready_d = (state == IDLE) & ~flush_lower_wb;
  assign accept          = dec_div_valid_d & dec_div_ready_d;
  assign capture         = exu_div_finish & ~flush_lower_wb &
                           ((state == ISSUE) | (state == BUSY));

  dec_div_wdog u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != BUSY),
    .en     (state == BUSY),
    .expire (wdog_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_q     <= 5'd0;
      unsign_q <= 1'b0;
      rem_q    <= 1'b0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        rd_q     <= dec_div_rd_d;
        unsign_q <= dec_div_unsign_d;
        rem_q    <= dec_div_rem_d;
        rs1_q    <= dec_div_rs1_d;
        rs2_q    <= dec_div_rs2_d;
      end
      if (capture) begin
        result_q <= exu_div_result;
      end
    end
  end

  // Flush beats finish, and finish beats a coincident watchdog expiry.
  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    case (state)
      IDLE:  if (accept) next_state = ISSUE;
      ISSUE: begin
        if (flush_lower_wb)      next_state = IDLE;
        else if (exu_div_finish) next_state = WB;
        else                     next_state = BUSY;
      end
      BUSY: begin
        if (flush_lower_wb)      next_state = IDLE;
        else if (exu_div_finish) next_state = WB;
        else if (wdog_expire) begin
          next_state = IDLE;
          timeout    = 1'b1;
        end
      end
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pkt        = '0;
    pkt.valid  = (state == ISSUE);
    pkt.unsign = pkt.valid & unsign_q;
    pkt.rem    = pkt.valid & rem_q;
  end

  assign div_p_valid     = pkt.valid;
  assign div_p_unsign    = pkt.unsign;
  assign div_p_rem       = pkt.rem;
  assign gpr_div_rs1_d   = pkt.valid ? rs1_q : 32'd0;
  assign gpr_div_rs2_d   = pkt.valid ? rs2_q : 32'd0;

  assign div_wen_wb      = (state == WB) & (rd_q != 5'd0) & ~flush_lower_wb;
  assign div_waddr_wb    = (state == WB) ? rd_q : 5'd0;
  assign div_wdata_wb    = (state == WB) ? result_q : 32'd0;
  assign div_busy        = (state != IDLE);
  assign div_timeout_err = timeout;

endmodule

// File: tb/tb_dec_div_issue.sv
// tb/tb_dec_div_issue.sv - directed vector bench for dec_div_issue
module tb_dec_div_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        v, u, r, fl, fin, stall;
  logic [4:0]  rd;
  logic [31:0] rs1, rs2, res;
  logic        rdy, pv, pu, pr, busy, wen, err;
  logic [31:0] prs1, prs2, wdata;
  logic [4:0]  waddr;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dec_div_issue dut (
    .clk              (clk),
    .rst              (rst),
    .dec_div_valid_d  (v),
    .dec_div_unsign_d (u),
    .dec_div_rem_d    (r),
    .dec_div_rd_d     (rd),
    .dec_div_rs1_d    (rs1),
    .dec_div_rs2_d    (rs2),
    .dec_div_ready_d  (rdy),
    .flush_lower_wb   (fl),
    .div_p_valid      (pv),
    .div_p_unsign     (pu),
    .div_p_rem        (pr),
    .gpr_div_rs1_d    (prs1),
    .gpr_div_rs2_d    (prs2),
    .exu_div_stall    (stall),
    .exu_div_finish   (fin),
    .exu_div_result   (res),
    .div_wen_wb       (wen),
    .div_waddr_wb     (waddr),
    .div_wdata_wb     (wdata),
    .div_busy         (busy),
    .div_timeout_err  (err)
  );

  typedef struct {
    logic        v, u, r;
    logic [4:0]  rd;
    logic [31:0] rs1, rs2;
    logic        fl, fin;
    logic [31:0] res;
    logic        rdy, pv, pu, pr;
    logic [31:0] prs1, prs2;
    logic        busy, wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic iv, logic iu, logic ir, logic [4:0] ird,
                              logic [31:0] irs1, logic [31:0] irs2, logic ifl,
                              logic ifin, logic [31:0] ires, logic erdy,
                              logic epv, logic epu, logic epr, logic [31:0] eprs1,
                              logic [31:0] eprs2, logic ebusy, logic ewen,
                              logic [4:0] ewaddr, logic [31:0] ewdata, logic eerr);
    vec_t t;
    t.v = iv; t.u = iu; t.r = ir; t.rd = ird; t.rs1 = irs1; t.rs2 = irs2;
    t.fl = ifl; t.fin = ifin; t.res = ires;
    t.rdy = erdy; t.pv = epv; t.pu = epu; t.pr = epr; t.prs1 = eprs1;
    t.prs2 = eprs2; t.busy = ebusy; t.wen = ewen; t.waddr = ewaddr;
    t.wdata = ewdata; t.err = eerr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    v = 0; u = 0; r = 0; rd = 0; rs1 = 0; rs2 = 0; fl = 0; fin = 0; res = 0;
  endtask

  task automatic accept(input logic iu, input logic ir, input logic [4:0] ird,
                        input logic [31:0] irs1, input logic [31:0] irs2);
    quiet();
    v = 1; u = iu; r = ir; rd = ird; rs1 = irs1; rs2 = irs2;
    tick();
    quiet();
  endtask

  initial begin
    int pulses;
    int found;

    stall = 0;
    quiet();
    rst = 1;

    //     v u r rd  rs1      rs2   fl fin res      rdy pv pu pr prs1     prs2 busy wen waddr wdata err
    vecs[0]  = mk(1,0,1, 3, 7,       2,    0, 0, 0,       1, 0, 0, 0, 0,      0,   0, 0, 0, 0,     0);
    vecs[1]  = mk(0,0,0, 0, 0,       0,    0, 1, 1,       0, 1, 0, 1, 7,      2,   1, 0, 0, 0,     0);
    vecs[2]  = mk(0,0,0, 0, 0,       0,    0, 0, 0,       0, 0, 0, 0, 0,      0,   1, 1, 3, 1,     0);
    vecs[3]  = mk(0,0,0, 0, 0,       0,    0, 1, 32'h55,  1, 0, 0, 0, 0,      0,   0, 0, 0, 0,     0);
    vecs[4]  = mk(0,0,0, 0, 0,       0,    0, 0, 0,       1, 0, 0, 0, 0,      0,   0, 0, 0, 0,     0);
    vecs[5]  = mk(1,1,0, 0, 32'h100, 2,    0, 0, 0,       1, 0, 0, 0, 0,      0,   0, 0, 0, 0,     0);
    vecs[6]  = mk(0,0,0, 0, 0,       0,    0, 0, 0,       0, 1, 1, 0, 32'h100,2,   1, 0, 0, 0,     0);
    vecs[7]  = mk(0,0,0, 0, 0,       0,    0, 0, 0,       0, 0, 0, 0, 0,      0,   1, 0, 0, 0,     0);
    vecs[8]  = mk(0,0,0, 0, 0,       0,    0, 1, 32'h80,  0, 0, 0, 0, 0,      0,   1, 0, 0, 0,     0);
    vecs[9]  = mk(0,0,0, 0, 0,       0,    0, 0, 0,       0, 0, 0, 0, 0,      0,   1, 0, 0, 32'h80,0);
    vecs[10] = mk(0,0,0, 0, 0,       0,    0, 0, 0,       1, 0, 0, 0, 0,      0,   0, 0, 0, 0,     0);
    vecs[11] = mk(1,0,0, 9, 32'h20,  4,    0, 0, 0,       1, 0, 0, 0, 0,      0,   0, 0, 0, 0,     0);
    vecs[12] = mk(0,0,0, 0, 0,       0,    0, 0, 0,       0, 1, 0, 0, 32'h20, 4,   1, 0, 0, 0,     0);
    vecs[13] = mk(0,0,0, 0, 0,       0,    1, 1, 8,       0, 0, 0, 0, 0,      0,   1, 0, 0, 0,     0);
    vecs[14] = mk(0,0,0, 0, 0,       0,    0, 0, 0,       1, 0, 0, 0, 0,      0,   0, 0, 0, 0,     0);
    vecs[15] = mk(1,0,0, 4, 9,       3,    0, 0, 0,       1, 0, 0, 0, 0,      0,   0, 0, 0, 0,     0);
    vecs[16] = mk(0,0,0, 0, 0,       0,    0, 1, 3,       0, 1, 0, 0, 9,      3,   1, 0, 0, 0,     0);
    vecs[17] = mk(0,0,0, 0, 0,       0,    1, 0, 0,       0, 0, 0, 0, 0,      0,   1, 0, 4, 3,     0);
    vecs[18] = mk(0,0,0, 0, 0,       0,    0, 0, 0,       1, 0, 0, 0, 0,      0,   0, 0, 0, 0,     0);
    vecs[19] = mk(1,0,0, 6, 5,       5,    1, 0, 0,       0, 0, 0, 0, 0,      0,   0, 0, 0, 0,     0);
    vecs[20] = mk(0,0,0, 0, 0,       0,    0, 0, 0,       1, 0, 0, 0, 0,      0,   0, 0, 0, 0,     0);

    // reset state
    #12;
    chk("rst_rdy", rdy, 1); chk("rst_busy", busy, 0); chk("rst_pv", pv, 0);
    chk("rst_rs1", prs1, 0); chk("rst_wen", wen, 0); chk("rst_wdata", wdata, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 0;
    tick();

    foreach (vecs[i]) begin
      v = vecs[i].v; u = vecs[i].u; r = vecs[i].r; rd = vecs[i].rd;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; fl = vecs[i].fl;
      fin = vecs[i].fin; res = vecs[i].res;
      #1;
      chk($sformatf("v%0d_rdy", i), rdy, vecs[i].rdy);
      chk($sformatf("v%0d_pv", i), pv, vecs[i].pv);
      chk($sformatf("v%0d_pu", i), pu, vecs[i].pu);
      chk($sformatf("v%0d_pr", i), pr, vecs[i].pr);
      chk($sformatf("v%0d_prs1", i), prs1, vecs[i].prs1);
      chk($sformatf("v%0d_prs2", i), prs2, vecs[i].prs2);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d_wen", i), wen, vecs[i].wen);
      chk($sformatf("v%0d_waddr", i), waddr, vecs[i].waddr);
      chk($sformatf("v%0d_wdata", i), wdata, vecs[i].wdata);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      tick();
    end
    quiet();

    // long divide: finish 34 cycles after accept
    accept(1, 0, 5, 32'h100, 32'h2);
    pulses = 0;
    for (int c = 1; c <= 34; c++) begin
      fin = (c == 34); res = 32'h80;
      #1;
      if (pv) pulses++;
      tick();
    end
    quiet();
    #1;
    chk("long_pulses", pulses, 1);
    chk("long_wen", wen, 1); chk("long_waddr", waddr, 5); chk("long_wdata", wdata, 32'h80);
    tick();
    chk("long_idle", busy, 0);

    // flush in BUSY cycle 10, then a late finish
    accept(0, 0, 12, 32'd50, 32'd5);
    tick();
    for (int b = 0; b < 10; b++) tick();
    fl = 1;
    tick();
    fl = 0; fin = 1; res = 32'd10;
    #1;
    chk("flush_rdy", rdy, 1); chk("flush_busy", busy, 0);
    tick();
    fin = 0;
    #1;
    chk("flush_wen", wen, 0); chk("flush_busy2", busy, 0);
    tick();

    // watchdog expiry without finish
    accept(0, 1, 2, 32'd9, 32'd0);
    tick();
    found = -1;
    for (int b = 0; b < 100; b++) begin
      #1;
      if (err) begin
        found = b;
        break;
      end
      tick();
    end
    chk("wdog_cycle", found, 63);
    tick();
    chk("wdog_busy", busy, 0); chk("wdog_err_once", err, 0); chk("wdog_wen", wen, 0);

    // finish coinciding with expiry
    accept(1, 0, 8, 32'd1, 32'd1);
    tick();
    for (int b = 0; b < 63; b++) tick();
    fin = 1; res = 32'hABC;
    #1;
    chk("race_err", err, 0);
    tick();
    fin = 0;
    #1;
    chk("race_wen", wen, 1); chk("race_wdata", wdata, 32'hABC);
    tick();

    // async reset mid-divide, then a fresh request
    accept(0, 0, 7, 32'd40, 32'd8);
    tick(); tick(); tick();
    #1;
    rst = 1;
    #1;
    chk("arst_busy", busy, 0); chk("arst_rdy", rdy, 1); chk("arst_wen", wen, 0);
    chk("arst_err", err, 0);
    tick();
    rst = 0;
    tick();
    v = 1; u = 1; rd = 11; rs1 = 32'd77; rs2 = 32'd7;
    #1;
    chk("post_rst_rdy", rdy, 1);
    tick();
    quiet();
    #1;
    chk("post_rst_pv", pv, 1); chk("post_rst_rs1", prs1, 32'd77);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
